// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised oversampling UART receiver with valid/ready word delivery.
//
// The serial line passes a 2-FF synchroniser. On each sample_en tick the FSM
// advances through START -> DATA -> (PAR) -> STOP. Each bit is voted from the
// samples taken at ticks M-1, M and M+1 (M = OVERSAMPLE/2). The bit value is
// decided at tick M+1.
//
// Parameters:
//   OVERSAMPLE  sample ticks per bit (even, >= 8)
//   DATA_BITS   data bits per frame (5..9), LSB first
//   PARITY      0 none, 1 odd, 2 even
//   STOP_BITS   1 or 2
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   sample_en   oversample tick (1-clk pulse at OVERSAMPLE x baud)
//   in          asynchronous serial line, idle high
//   data        received word
//   valid       data/flags valid, held until accepted
//   ready       consumer accepts when valid & ready
//   frame_err   a stop bit was sampled 0
//   parity_err  parity mismatch (always 0 when PARITY = 0)
//   brk         break: data, parity and stop bits all 0
//   overrun     an unaccepted word was overwritten by this one
//   busy        receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 brk,
    output logic                 overrun,
    output logic                 busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_LO  = TW'(M - 1);
    localparam logic [TW-1:0] T_MID = TW'(M);
    localparam logic [TW-1:0] T_HI  = TW'(M + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t state_reg, state_next;

    logic                 sync1_reg, sync2_reg;
    logic                 last_reg;
    logic [TW-1:0]        tick_reg;
    logic [1:0]           samp_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc_reg;
    logic                 zero_reg;
    logic                 fe_reg;

    logic line;
    logic vote;
    logic bit_decide;
    logic bit_end;
    logic commit;
    logic pe_new;

    assign line       = sync2_reg;
    // Majority of the two stored samples and the live sample at tick M+1.
    assign vote       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & line) | (samp_reg[1] & line);
    assign bit_decide = sample_en && (tick_reg == T_HI);
    assign bit_end    = sample_en && (tick_reg == T_END);
    assign busy       = (state_reg != ST_IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and commit strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Falling edge only: a line stuck low never starts a frame.
                if (sample_en && !line && last_reg) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_decide && vote) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt_reg == BITS_LAST)) begin
                    state_next = (PARITY != 0) ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave as soon as the last stop bit is decided so a
                // back-to-back start edge can be caught.
                if (bit_decide && (stop_cnt_reg == STOP_LAST)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // par_acc_reg holds XOR of data bits and the received parity bit.
    always_comb begin
        case (PARITY)
            1:       pe_new = ~par_acc_reg;
            2:       pe_new = par_acc_reg;
            default: pe_new = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Synchroniser, sampling and frame accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            last_reg     <= 1'b1;
            tick_reg     <= '0;
            samp_reg     <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            par_acc_reg  <= 1'b0;
            zero_reg     <= 1'b1;
            fe_reg       <= 1'b0;
        end else begin
            sync1_reg <= in;
            sync2_reg <= sync1_reg;
            if (sample_en) begin
                last_reg <= line;
                if (state_reg == ST_IDLE) begin
                    tick_reg     <= '0;
                    bit_cnt_reg  <= '0;
                    stop_cnt_reg <= 1'b0;
                    par_acc_reg  <= 1'b0;
                    zero_reg     <= 1'b1;
                    fe_reg       <= 1'b0;
                end else begin
                    tick_reg <= (tick_reg == T_END) ? '0 : tick_reg + TW'(1);
                    if (tick_reg == T_LO) begin
                        samp_reg[0] <= line;
                    end
                    if (tick_reg == T_MID) begin
                        samp_reg[1] <= line;
                    end
                    if (tick_reg == T_HI) begin
                        case (state_reg)
                            ST_DATA: begin
                                shift_reg   <= {vote, shift_reg[DATA_BITS-1:1]};
                                par_acc_reg <= par_acc_reg ^ vote;
                                zero_reg    <= zero_reg & ~vote;
                            end
                            ST_PAR: begin
                                par_acc_reg <= par_acc_reg ^ vote;
                                zero_reg    <= zero_reg & ~vote;
                            end
                            ST_STOP: begin
                                fe_reg       <= fe_reg | ~vote;
                                zero_reg     <= zero_reg & ~vote;
                                stop_cnt_reg <= stop_cnt_reg + 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (bit_end && (state_reg == ST_DATA)) begin
                        bit_cnt_reg <= bit_cnt_reg + BW'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output word and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            // Last stop bit vote is still live this cycle, fold it in here.
            data       <= shift_reg;
            valid      <= 1'b1;
            frame_err  <= fe_reg | ~vote;
            parity_err <= pe_new;
            brk        <= zero_reg & ~vote;
            overrun    <= valid & ~ready;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Two receivers share clock, reset, sample_en and ready: u_dut_a is 8N1,
// u_dut_p is 8E1. Expected words are queued as frames are driven and compared
// by per-receiver monitors as words appear on the outputs.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int OS = 16;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       bk;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en;
    logic       ready = 1'b1;
    logic       line_a = 1'b1;
    logic       line_p = 1'b1;
    int         se_div = 1;
    int         se_cnt = 0;

    logic [7:0] data_a, data_p;
    logic       valid_a, valid_p;
    logic       fe_a, fe_p, pe_a, pe_p, bk_a, bk_p, ov_a, ov_p, busy_a, busy_p;

    int checks = 0;
    int errors = 0;
    int words_a = 0;
    int words_p = 0;
    int vhi_a = 0;

    exp_t q_a[$];
    exp_t q_p[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (se_cnt >= se_div - 1) se_cnt <= 0;
        else se_cnt <= se_cnt + 1;
    end
    assign sample_en = (se_cnt == 0);

    uart_rx_param #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .sample_en(sample_en), .in(line_a),
        .data(data_a), .valid(valid_a), .ready(ready),
        .frame_err(fe_a), .parity_err(pe_a), .brk(bk_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_param #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_p (
        .clk(clk), .rst(rst), .sample_en(sample_en), .in(line_p),
        .data(data_p), .valid(valid_p), .ready(ready),
        .frame_err(fe_p), .parity_err(pe_p), .brk(bk_p), .overrun(ov_p), .busy(busy_p)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // A new word is on the outputs when valid rises, when valid stays high
    // after an accept, or when overrun rises while valid is held.
    logic va_q = 1'b0, ra_q = 1'b0, oa_q = 1'b0;
    exp_t ea;
    always @(negedge clk) begin
        if (valid_a) vhi_a++;
        if (!rst && valid_a && (!va_q || ra_q || (ov_a && !oa_q))) begin
            words_a++;
            $display("rx a: data=0x%02h fe=%0d pe=%0d brk=%0d ov=%0d", data_a, fe_a, pe_a, bk_a, ov_a);
            if (q_a.size() == 0) begin
                chk("a_unexpected_word", 32'(valid_a), 32'd0);
            end else begin
                ea = q_a.pop_front();
                chk("a_data", 32'(data_a), 32'(ea.d));
                chk("a_frame_err", 32'(fe_a), 32'(ea.fe));
                chk("a_parity_err", 32'(pe_a), 32'(ea.pe));
                chk("a_brk", 32'(bk_a), 32'(ea.bk));
                chk("a_overrun", 32'(ov_a), 32'(ea.ov));
            end
        end
        va_q = valid_a & ~rst;
        ra_q = ready;
        oa_q = ov_a;
    end

    logic vp_q = 1'b0, rp_q = 1'b0, op_q = 1'b0;
    exp_t ep;
    always @(negedge clk) begin
        if (!rst && valid_p && (!vp_q || rp_q || (ov_p && !op_q))) begin
            words_p++;
            $display("rx p: data=0x%02h fe=%0d pe=%0d brk=%0d ov=%0d", data_p, fe_p, pe_p, bk_p, ov_p);
            if (q_p.size() == 0) begin
                chk("p_unexpected_word", 32'(valid_p), 32'd0);
            end else begin
                ep = q_p.pop_front();
                chk("p_data", 32'(data_p), 32'(ep.d));
                chk("p_frame_err", 32'(fe_p), 32'(ep.fe));
                chk("p_parity_err", 32'(pe_p), 32'(ep.pe));
                chk("p_brk", 32'(bk_p), 32'(ep.bk));
                chk("p_overrun", 32'(ov_p), 32'(ep.ov));
            end
        end
        vp_q = valid_p & ~rst;
        rp_q = ready;
        op_q = ov_p;
    end

    task automatic drive_bit(input bit port, input logic b, input int div);
        #1;
        if (port) line_p = b;
        else line_a = b;
        repeat (OS * div) @(posedge clk);
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send_frame(input bit port, input logic [7:0] d, input int par,
                              input logic stop, input int div, input bit push, input logic ov);
        exp_t e;
        if (push) begin
            e.d  = d;
            e.fe = ~stop;
            e.pe = (par >= 0) ? ((^d) ^ par[0]) : 1'b0;   // even parity
            e.bk = (d == 8'h00) && !stop && ((par < 0) || !par[0]);
            e.ov = ov;
            if (port) q_p.push_back(e);
            else q_a.push_back(e);
        end
        drive_bit(port, 1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(port, d[i], div);
        if (par >= 0) drive_bit(port, par[0], div);
        drive_bit(port, stop, div);
    endtask

    initial begin
        int w0;
        int v0;
        bit fell;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_flags", 32'({fe_a, pe_a, bk_a, ov_a}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);

        // 1: 8N1 0xA5, valid for exactly one clock
        v0 = vhi_a;
        send_frame(1'b0, 8'hA5, -1, 1'b1, 1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 2);
        chk("t1_valid_cycles", 32'(vhi_a - v0), 32'd1);

        // 2: short low glitch is a false start
        w0 = words_a;
        @(posedge clk);
        #1 line_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 line_a = 1'b1;
        fell = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) chk("t2_busy_rise", 32'(busy_a), 32'd1);
            if (!busy_a && !fell) fell = 1'b1;
        end
        chk("t2_busy_fall", 32'(fell), 32'd1);
        repeat (40) @(posedge clk);
        chk("t2_no_word", 32'(words_a - w0), 32'd0);

        // 3: even parity, bad then good parity bit
        send_frame(1'b1, 8'h3C, 1, 1'b1, 1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 2);
        send_frame(1'b1, 8'h3C, 0, 1'b1, 1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 2);

        // 4: framing error, then break with line held low
        send_frame(1'b0, 8'h55, -1, 1'b0, 1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 2);
        send_frame(1'b0, 8'h00, -1, 1'b0, 1, 1'b1, 1'b0);
        w0 = words_a;
        drive_bit(1'b0, 1'b0, 3);
        chk("t4_low_no_word", 32'(words_a - w0), 32'd0);
        drive_bit(1'b0, 1'b1, 2);
        chk("t4_rise_no_word", 32'(words_a - w0), 32'd0);

        // 5: overrun with ready low, then accept
        #1 ready = 1'b0;
        send_frame(1'b0, 8'h11, -1, 1'b1, 1, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1);
        send_frame(1'b0, 8'h22, -1, 1'b1, 1, 1'b1, 1'b1);
        drive_bit(1'b0, 1'b1, 1);
        @(negedge clk);
        chk("t5_valid_held", 32'(valid_a), 32'd1);
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        chk("t5_valid_before_accept", 32'(valid_a), 32'd1);
        @(negedge clk);
        chk("t5_valid_fall", 32'(valid_a), 32'd0);
        chk("t5_data_hold", 32'(data_a), 32'h22);

        // 6: reset mid-frame, then slower sample_en
        fork
            send_frame(1'b0, 8'hFF, -1, 1'b1, 1, 1'b0, 1'b0);
            begin
                repeat (OS * 4) @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                chk("t6_busy_before_rst", 32'(busy_a), 32'd1);
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("t6_rst_valid", 32'(valid_a), 32'd0);
                chk("t6_rst_data", 32'(data_a), 32'd0);
                chk("t6_rst_busy", 32'(busy_a), 32'd0);
                chk("t6_rst_flags", 32'({fe_a, pe_a, bk_a, ov_a}), 32'd0);
            end
        join
        w0 = words_a;
        drive_bit(1'b0, 1'b1, 2);
        chk("t6_no_partial_word", 32'(words_a - w0), 32'd0);
        se_div = 4;
        drive_bit(1'b0, 1'b1, 4);
        send_frame(1'b0, 8'h5A, -1, 1'b1, 4, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 8);

        chk("end_queue_a_empty", 32'(q_a.size()), 32'd0);
        chk("end_queue_p_empty", 32'(q_p.size()), 32'd0);
        chk("end_words_p", 32'(words_p), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
